// File: rtl/io_input_scan_ctrl.sv
// Round-robin scan controller for memory-mapped input ports: synchronises,
// debounces and latches each 32-bit port, flags changes and raises an interrupt.
module io_input_scan_ctrl #(
  parameter int         N_PORTS    = 3,
  parameter int         SCAN_DIV   = 1024,
  parameter int         DEBOUNCE   = 4,
  parameter logic [5:0] STATUS_SEL = 6'b111000
) (
  input  logic                   io_clk,
  input  logic                   reset,
  input  logic [31:0]            addr,
  input  logic                   rd_en,
  input  logic [32*N_PORTS-1:0]  in_ports,
  input  logic                   irq_en,
  output logic [31:0]            io_read_data,
  output logic                   irq,
  output logic [2:0]             scan_idx
);

  localparam int              PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB       = 4'(DEBOUNCE);
  localparam logic [3:0]      NP4       = 4'(N_PORTS);
  localparam logic [2:0]      LAST_IDX  = 3'(N_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                  state_r;
  logic [32*N_PORTS-1:0]   sync1_r;
  logic [32*N_PORTS-1:0]   sync2_r;
  logic [32*N_PORTS-1:0]   cand_r;
  logic [32*N_PORTS-1:0]   stable_r;
  logic [4*N_PORTS-1:0]    cnt_r;
  logic [N_PORTS-1:0]      changed_r;
  logic [PW-1:0]           presc_r;
  logic [2:0]              idx_r;
  logic [31:0]             sample_r;

  logic                    tick_s;
  logic [31:0]             sync_sel_s;
  logic [31:0]             cur_cand_s;
  logic [31:0]             cur_stable_s;
  logic [3:0]              cur_cnt_s;
  logic [3:0]              ncnt_s;
  logic                    accept_s;
  logic [5:0]              sel_s;
  logic                    port_hit_s;
  logic [N_PORTS-1:0]      clr_mask_s;
  logic                    unused_addr_s;

  assign tick_s        = (presc_r == PRESC_MAX);
  assign sel_s         = addr[7:2];
  assign port_hit_s    = (sel_s[5:3] == 3'b110) && ({1'b0, sel_s[2:0]} < NP4);
  assign unused_addr_s = &{1'b0, addr[31:8], addr[1:0]};
  assign irq           = irq_en & (|changed_r);
  assign scan_idx      = idx_r;

  // Two-flop synchroniser on every input bit.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      sync1_r <= {(32*N_PORTS){1'b0}};
      sync2_r <= {(32*N_PORTS){1'b0}};
    end else begin
      sync1_r <= in_ports;
      sync2_r <= sync1_r;
    end
  end

  // Free-running scan prescaler.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      presc_r <= {PW{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Select the per-port state addressed by the scan index.
  always_comb begin
    sync_sel_s   = 32'h0;
    cur_cand_s   = 32'h0;
    cur_stable_s = 32'h0;
    cur_cnt_s    = 4'h0;
    for (int k = 0; k < N_PORTS; k++) begin
      sync_sel_s   = sync_sel_s   | ((idx_r == 3'(k)) ? sync2_r[32*k +: 32]  : 32'h0);
      cur_cand_s   = cur_cand_s   | ((idx_r == 3'(k)) ? cand_r[32*k +: 32]   : 32'h0);
      cur_stable_s = cur_stable_s | ((idx_r == 3'(k)) ? stable_r[32*k +: 32] : 32'h0);
      cur_cnt_s    = cur_cnt_s    | ((idx_r == 3'(k)) ? cnt_r[4*k +: 4]      : 4'h0);
    end
  end

  // Debounce arithmetic: saturating run length of identical samples.
  always_comb begin
    if (sample_r == cur_cand_s) begin
      ncnt_s = (cur_cnt_s >= DEB) ? DEB : (cur_cnt_s + 4'd1);
    end else begin
      ncnt_s = 4'd1;
    end
    accept_s = (ncnt_s == DEB) && (sample_r != cur_stable_s);
  end

  // Read-clear mask for the port word being read.
  always_comb begin
    clr_mask_s = {N_PORTS{1'b0}};
    for (int k = 0; k < N_PORTS; k++) begin
      clr_mask_s[k] = rd_en && port_hit_s && (sel_s[2:0] == 3'(k));
    end
  end

  // CPU read mux; unmapped codes read as zero.
  always_comb begin
    io_read_data = 32'h0;
    if (port_hit_s) begin
      for (int k = 0; k < N_PORTS; k++) begin
        io_read_data = io_read_data |
                       ((sel_s[2:0] == 3'(k)) ? stable_r[32*k +: 32] : 32'h0);
      end
    end else if (sel_s == STATUS_SEL) begin
      io_read_data = {{(32-N_PORTS){1'b0}}, changed_r};
    end else begin
      io_read_data = 32'h0;
    end
  end

  // Scan FSM with per-port debounce state and change flags.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= 3'd0;
      sample_r  <= 32'h0;
      cand_r    <= {(32*N_PORTS){1'b0}};
      stable_r  <= {(32*N_PORTS){1'b0}};
      cnt_r     <= {(4*N_PORTS){1'b0}};
      changed_r <= {N_PORTS{1'b0}};
    end else begin
      // Clear first so a same-cycle set below takes priority.
      changed_r <= changed_r & ~clr_mask_s;
      case (state_r)
        IDLE: begin
          if (tick_s) begin
            state_r <= SAMPLE;
          end else begin
            state_r <= IDLE;
          end
        end
        SAMPLE: begin
          sample_r <= sync_sel_s;
          state_r  <= COMMIT;
        end
        COMMIT: begin
          for (int k = 0; k < N_PORTS; k++) begin
            if (idx_r == 3'(k)) begin
              cand_r[32*k +: 32] <= sample_r;
              cnt_r[4*k +: 4]    <= ncnt_s;
              if (accept_s) begin
                stable_r[32*k +: 32] <= sample_r;
                changed_r[k]         <= 1'b1;
              end
            end
          end
          if (idx_r == LAST_IDX) begin
            idx_r   <= 3'd0;
            state_r <= IDLE;
          end else begin
            idx_r   <= idx_r + 3'd1;
            state_r <= SAMPLE;
          end
        end
        default: begin
          idx_r   <= 3'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_input_scan_ctrl.sv
// Scoreboard bench for io_input_scan_ctrl (N_PORTS=3, SCAN_DIV=16, DEBOUNCE=3).
module tb_io_input_scan_ctrl;

  localparam int N_PORTS = 3;

  logic                  io_clk;
  logic                  reset;
  logic [31:0]           addr;
  logic                  rd_en;
  logic [32*N_PORTS-1:0] in_ports;
  logic                  irq_en;
  logic [31:0]           io_read_data;
  logic                  irq;
  logic [2:0]            scan_idx;

  io_input_scan_ctrl #(
    .N_PORTS   (3),
    .SCAN_DIV  (16),
    .DEBOUNCE  (3),
    .STATUS_SEL(6'b111000)
  ) dut (
    .io_clk      (io_clk),
    .reset       (reset),
    .addr        (addr),
    .rd_en       (rd_en),
    .in_ports    (in_ports),
    .irq_en      (irq_en),
    .io_read_data(io_read_data),
    .irq         (irq),
    .scan_idx    (scan_idx)
  );

  localparam int K_RD  = 0;
  localparam int K_IRQ = 1;
  localparam int K_IDX = 2;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  logic  chk_req;

  initial begin
    io_clk = 1'b0;
    forever #5 io_clk = ~io_clk;
  end

  // Cycles since the last reset release.
  always @(posedge io_clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Monitor: pops the expected value whenever a check is presented.
  always @(negedge io_clk) begin
    if (chk_req) begin
      total = total + 1;
      if (sb.size() == 0) begin
        bad = bad + 1;
        $display("FAIL sb_empty: no expected value queued");
      end else begin
        item_t it;
        logic [31:0] act;
        it = sb.pop_front();
        case (it.kind)
          K_RD:    act = io_read_data;
          K_IRQ:   act = {31'h0, irq};
          default: act = {29'h0, scan_idx};
        endcase
        if (act !== it.exp) begin
          bad = bad + 1;
          $display("FAIL %s: got %h expected %h (cyc %0d)", it.name, act, it.exp, cyc);
        end
      end
    end
  end

  task automatic issue(input int kind, input logic [31:0] a, input logic rd,
                       input logic [31:0] exp, input string name);
    item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
    addr    = a;
    rd_en   = rd;
    chk_req = 1'b1;
    @(posedge io_clk);
    #1;
    rd_en   = 1'b0;
    chk_req = 1'b0;
    addr    = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic r, input logic [31:0] exp, input string name);
    issue(K_RD, a, r, exp, name);
  endtask

  task automatic goto(input int n);
    if (cyc > n) begin
      bad = bad + 1;
      $display("FAIL sched: at cycle %0d expected <= %0d", cyc, n);
    end
    while (cyc < n) begin
      @(posedge io_clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    in_ports = {(32*N_PORTS){1'b1}};
    irq_en   = 1'b1;
    addr     = 32'h0;
    rd_en    = 1'b0;
    chk_req  = 1'b0;
    @(posedge io_clk);
    #1;

    // Reset state with all-ones inputs.
    rd(32'hC0, 1'b0, 32'h0, "rst_p0");
    rd(32'hC4, 1'b0, 32'h0, "rst_p1");
    rd(32'hC8, 1'b0, 32'h0, "rst_p2");
    issue(K_IRQ, 32'h0, 1'b0, 32'h0, "rst_irq");
    issue(K_IDX, 32'h0, 1'b0, 32'h0, "rst_idx");
    in_ports = {(32*N_PORTS){1'b0}};
    reset    = 1'b0;

    // Accept port1 = A5 on the third scan (COMMIT idx1 at cycle 52).
    goto(1);
    in_ports[63:32] = 32'h0000_00A5;
    goto(19);
    issue(K_IDX, 32'h0, 1'b0, 32'd1, "idx_mid_scan");
    goto(51);
    rd(32'hC4, 1'b0, 32'h0, "p1_before_accept");
    rd(32'hE0, 1'b0, 32'h2, "status_p1");
    issue(K_IRQ, 32'h0, 1'b0, 32'h1, "irq_set");
    rd(32'hC4, 1'b1, 32'hA5, "p1_read_clear");
    issue(K_IRQ, 32'h0, 1'b0, 32'h0, "irq_cleared");
    rd(32'hE0, 1'b0, 32'h0, "status_after_clear");

    // Glitch on port0 seen by exactly one scan.
    goto(58);
    in_ports[31:0] = 32'h5;
    goto(70);
    in_ports[31:0] = 32'h0;
    goto(120);
    in_ports[95:64] = 32'hDEAD_BEEF;
    rd(32'hC0, 1'b0, 32'h0, "glitch_p0");
    rd(32'hE0, 1'b0, 32'h0, "glitch_status");

    // Read-clear of port2 in the same cycle its COMMIT sets the flag.
    goto(165);
    rd(32'hC8, 1'b1, 32'h0, "race_read");
    rd(32'hE0, 1'b0, 32'h4, "race_status");
    issue(K_IRQ, 32'h0, 1'b0, 32'h1, "race_irq");
    rd(32'hC8, 1'b1, 32'hDEAD_BEEF, "p2_read_clear");
    rd(32'hE0, 1'b0, 32'h0, "p2_status_clear");

    // Abort in COMMIT of idx1.
    goto(178);
    issue(K_IDX, 32'h0, 1'b0, 32'd1, "idx_before_abort");
    reset = 1'b1;
    rd(32'hC4, 1'b0, 32'h0, "abort_p1");
    rd(32'hC8, 1'b0, 32'h0, "abort_p2");
    rd(32'hE0, 1'b0, 32'h0, "abort_status");
    issue(K_IRQ, 32'h0, 1'b0, 32'h0, "abort_irq");
    issue(K_IDX, 32'h0, 1'b0, 32'h0, "abort_idx");
    reset = 1'b0;
    goto(17);
    issue(K_IDX, 32'h0, 1'b0, 32'd0, "restart_idx0");
    issue(K_IDX, 32'h0, 1'b0, 32'd1, "restart_idx1");

    // Decode and irq masking; ports 1 and 2 re-accepted by cycle 54.
    goto(60);
    irq_en = 1'b0;
    rd(32'hDC, 1'b0, 32'h0, "unmapped_dc");
    rd(32'hCC, 1'b0, 32'h0, "unmapped_port3");
    issue(K_IRQ, 32'h0, 1'b0, 32'h0, "irq_masked");
    rd(32'hE0, 1'b0, 32'h6, "masked_status");
    rd(32'hC8, 1'b0, 32'hDEAD_BEEF, "p2_no_rd_en");
    rd(32'hE0, 1'b0, 32'h6, "status_no_clear");
    rd(32'hE0, 1'b1, 32'h6, "status_rd_en");
    rd(32'hE0, 1'b0, 32'h6, "status_still_set");
    irq_en = 1'b1;
    issue(K_IRQ, 32'h0, 1'b0, 32'h1, "irq_unmasked");

    @(posedge io_clk);
    #1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL sb_leftover: %0d entries remain, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
